// File: rtl/nand_sweep_pkg.sv
// Shared types and the golden reference function for the nand_sweep exhaustive gate checker.
package nand_sweep_pkg;

   localparam int MAX_W = 16;

   typedef enum logic [1:0] {
      MODE_NAND = 2'd0,
      MODE_AND  = 2'd1,
      MODE_NOR  = 2'd2,
      MODE_XOR  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Only the low `width` bits of pat take part in the reduction.
   function automatic logic golden(input mode_e mode, input logic [MAX_W-1:0] pat, input int width);
      logic all1, any1, par, res;
      all1 = 1'b1;
      any1 = 1'b0;
      par  = 1'b0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < width) begin
            all1 = all1 & pat[i];
            any1 = any1 | pat[i];
            par  = par ^ pat[i];
         end
      end
      case (mode)
         MODE_NAND: res = ~all1;
         MODE_AND:  res = all1;
         MODE_NOR:  res = ~any1;
         default:   res = par;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/nand_sweep_dly.sv
// sweep_dly: LAT-deep shift register carrying {strobe, expected, pattern} to line up with the DUT response.
module sweep_dly #(
   parameter int LAT = 1,
   parameter int EW  = 6
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [EW-1:0] ent_i,
   output logic [EW-1:0] head_o
);

   logic [LAT-1:0][EW-1:0] dly_q, dly_d;

   always_comb begin
      dly_d    = dly_q;
      dly_d[0] = ent_i;
      for (int i = 1; i < LAT; i++) begin
         dly_d[i] = dly_q[i-1];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dly_q <= '0;
      end else begin
         dly_q <= dly_d;
      end
   end

   assign head_o = dly_q[LAT-1];

endmodule

// File: rtl/nand_sweep.sv
// nand_sweep: walks all 2^WIDTH patterns into an external gate DUT and counts response mismatches.
// Optional first-failure capture is enabled by defining NAND_SWEEP_FIRST_ERR_EN.
module nand_sweep
   import nand_sweep_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int HOLD  = 1,
   parameter int LAT   = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] pat_out,
   output logic             pat_valid,
   input  logic             resp_in,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_cnt,
   output logic [WIDTH-1:0] first_err_pat,
   output logic             first_err_vld
);

   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam int EW = WIDTH + 2;

   state_e           state_q, state_d;
   mode_e            mode_q, mode_d;
   logic [WIDTH:0]   pat_q, pat_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [DW-1:0]    drn_q, drn_d;
   logic [CNT_W-1:0] err_q, err_d;

   logic             push;
   logic             start_ok;
   logic             active;
   logic             miss;
   logic [EW-1:0]    dly_in;
   logic [EW-1:0]    dly_head;
   logic             head_stb;
   logic             head_exp;
   logic [WIDTH-1:0] head_pat;

   assign start_ok = (state_q == IDLE) && start;
   assign active   = (state_q == RUN) || (state_q == DRAIN);
   assign dly_in   = {push, golden(mode_q, MAX_W'(pat_q[WIDTH-1:0]), WIDTH), pat_q[WIDTH-1:0]};
   assign {head_stb, head_exp, head_pat} = dly_head;
   assign miss     = active && head_stb && (resp_in != head_exp);

   sweep_dly #(
      .LAT (LAT),
      .EW  (EW)
   ) u_dly (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .ent_i  (dly_in),
      .head_o (dly_head)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      pat_d   = pat_q;
      hold_d  = hold_q;
      drn_d   = drn_q;
      push    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               mode_d  = mode_e'(mode);
               pat_d   = '0;
               hold_d  = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (hold_q == HW'(HOLD - 1)) begin
               push   = 1'b1;
               hold_d = '0;
               pat_d  = pat_q + (WIDTH+1)'(1);
               // Extra counter bit flags the wrap past the all-ones pattern.
               if (pat_d[WIDTH]) begin
                  state_d = DRAIN;
                  drn_d   = '0;
               end
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         DRAIN: begin
            if (drn_q == DW'(LAT - 1)) begin
               state_d = DONE;
            end else begin
               drn_d = drn_q + DW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      err_d = err_q;
      if (start_ok) begin
         err_d = '0;
      end else if (miss && (err_q != '1)) begin
         err_d = err_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mode_q  <= MODE_NAND;
         pat_q   <= '0;
         hold_q  <= '0;
         drn_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         pat_q   <= pat_d;
         hold_q  <= hold_d;
         drn_q   <= drn_d;
         err_q   <= err_d;
      end
   end

   assign pat_valid = (state_q == RUN);
   assign pat_out   = pat_valid ? pat_q[WIDTH-1:0] : '0;
   assign busy      = active;
   assign done      = (state_q == DONE);
   assign err_cnt   = err_q;

`ifdef NAND_SWEEP_FIRST_ERR_EN
   logic [WIDTH-1:0] fe_pat_q;
   logic             fe_vld_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fe_pat_q <= '0;
         fe_vld_q <= 1'b0;
      end else if (start_ok) begin
         fe_vld_q <= 1'b0;
      end else if (miss && !fe_vld_q) begin
         fe_pat_q <= head_pat;
         fe_vld_q <= 1'b1;
      end
   end

   assign first_err_pat = fe_pat_q;
   assign first_err_vld = fe_vld_q;
`else
   logic unused_head_pat;
   assign unused_head_pat = ^head_pat;
   assign first_err_pat   = '0;
   assign first_err_vld   = 1'b0;
`endif

endmodule

// File: tb/tb_nand_sweep.sv
// Bench for nand_sweep: three configurations driven by emulated gate DUTs, checked against a cycle-index model.
module tb_nand_sweep;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       st_r   [3];
   logic [1:0] md_r   [3];
   logic [1:0] fn_r   [3];
   int         kind_r [3];

   logic       resp_w [3];
   logic [3:0] po_w   [3];
   logic       pv_w   [3];
   logic       bz_w   [3];
   logic       dn_w   [3];
   logic [3:0] fp_w   [3];
   logic       fv_w   [3];
   logic [7:0] err0, err1;
   logic [2:0] err2;

   int checks = 0;
   int errors = 0;

   nand_sweep #(.WIDTH(4), .HOLD(1), .LAT(1), .CNT_W(8)) u0 (
      .clk(clk), .rst_n(rst_n), .start(st_r[0]), .mode(md_r[0]), .pat_out(po_w[0]),
      .pat_valid(pv_w[0]), .resp_in(resp_w[0]), .busy(bz_w[0]), .done(dn_w[0]),
      .err_cnt(err0), .first_err_pat(fp_w[0]), .first_err_vld(fv_w[0]));

   nand_sweep #(.WIDTH(4), .HOLD(3), .LAT(4), .CNT_W(8)) u1 (
      .clk(clk), .rst_n(rst_n), .start(st_r[1]), .mode(md_r[1]), .pat_out(po_w[1]),
      .pat_valid(pv_w[1]), .resp_in(resp_w[1]), .busy(bz_w[1]), .done(dn_w[1]),
      .err_cnt(err1), .first_err_pat(fp_w[1]), .first_err_vld(fv_w[1]));

   nand_sweep #(.WIDTH(4), .HOLD(1), .LAT(1), .CNT_W(3)) u2 (
      .clk(clk), .rst_n(rst_n), .start(st_r[2]), .mode(md_r[2]), .pat_out(po_w[2]),
      .pat_valid(pv_w[2]), .resp_in(resp_w[2]), .busy(bz_w[2]), .done(dn_w[2]),
      .err_cnt(err2), .first_err_pat(fp_w[2]), .first_err_vld(fv_w[2]));

   function automatic logic gold(input logic [1:0] fn, input logic [3:0] p);
      int ones;
      ones = $countones(p);
      case (fn)
         2'd0:    return ones != 4;
         2'd1:    return ones == 4;
         2'd2:    return ones == 0;
         default: return (ones % 2) == 1;
      endcase
   endfunction

   // kind: 0 correct gate, 1 stuck-at-1, 2 inverted (always wrong)
   function automatic logic drv(input int kind, input logic v);
      if (kind == 1) return 1'b1;
      if (kind == 2) return ~v;
      return v;
   endfunction

   logic       p0_q = 1'b0;
   logic       p2_q = 1'b0;
   logic [3:0] p1_q = 4'h0;

   always @(posedge clk) begin
      p0_q <= gold(fn_r[0], po_w[0]);
      p1_q <= {p1_q[2:0], gold(fn_r[1], po_w[1])};
      p2_q <= gold(fn_r[2], po_w[2]);
   end

   assign resp_w[0] = drv(kind_r[0], p0_q);
   assign resp_w[1] = drv(kind_r[1], p1_q[3]);
   assign resp_w[2] = drv(kind_r[2], p2_q);

   task automatic cmp(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Model state: k_m is the cycle index since the start edge (0 = idle).
   int         k_m    [3] = '{0, 0, 0};
   int         err_m  [3] = '{0, 0, 0};
   int         fpat_m [3] = '{0, 0, 0};
   logic       fvld_m [3] = '{1'b0, 1'b0, 1'b0};
   logic [1:0] mm_m   [3] = '{2'd0, 2'd0, 2'd0};

   task automatic chk(input int id, input int H, input int L, input int CM,
                      input logic st, input logic [1:0] md, input logic rs,
                      input logic [3:0] po, input logic pv, input logic bz, input logic dn,
                      input int er, input logic [3:0] fp, input logic fv);
      int n, k, j, p;
      logic epv;
      n = 16;
      if (!rst_n) begin
         k_m[id]    = 0;
         err_m[id]  = 0;
         fpat_m[id] = 0;
         fvld_m[id] = 1'b0;
      end
      k   = k_m[id];
      epv = (k >= 1) && (k <= n * H);
      cmp($sformatf("u%0d.pat_valid k=%0d", id, k), pv, epv);
      cmp($sformatf("u%0d.pat_out k=%0d", id, k), po, epv ? (k - 1) / H : 0);
      cmp($sformatf("u%0d.busy k=%0d", id, k), bz, (k >= 1) && (k <= n * H + L));
      cmp($sformatf("u%0d.done k=%0d", id, k), dn, k == n * H + L + 1);
      cmp($sformatf("u%0d.err_cnt k=%0d", id, k), er, err_m[id]);
`ifdef NAND_SWEEP_FIRST_ERR_EN
      cmp($sformatf("u%0d.first_err_vld k=%0d", id, k), fv, fvld_m[id]);
      cmp($sformatf("u%0d.first_err_pat k=%0d", id, k), fp, fpat_m[id]);
`else
      cmp($sformatf("u%0d.first_err_vld k=%0d", id, k), fv, 0);
      cmp($sformatf("u%0d.first_err_pat k=%0d", id, k), fp, 0);
`endif
      if (rst_n) begin
         if (k == 0) begin
            if (st) begin
               k_m[id]    = 1;
               mm_m[id]   = md;
               err_m[id]  = 0;
               fvld_m[id] = 1'b0;
            end
         end else begin
            j = k - L;
            if (j >= H && (j % H) == 0 && (j / H) <= n) begin
               p = j / H - 1;
               if (rs != gold(mm_m[id], 4'(p))) begin
                  if (err_m[id] < CM) err_m[id] = err_m[id] + 1;
                  if (!fvld_m[id]) begin
                     fvld_m[id] = 1'b1;
                     fpat_m[id] = p;
                  end
               end
            end
            k_m[id] = (k == n * H + L + 1) ? 0 : k + 1;
         end
      end
   endtask

   always @(negedge clk) begin
      chk(0, 1, 1, 255, st_r[0], md_r[0], resp_w[0], po_w[0], pv_w[0], bz_w[0], dn_w[0], int'(err0), fp_w[0], fv_w[0]);
      chk(1, 3, 4, 255, st_r[1], md_r[1], resp_w[1], po_w[1], pv_w[1], bz_w[1], dn_w[1], int'(err1), fp_w[1], fv_w[1]);
      chk(2, 1, 1, 7,   st_r[2], md_r[2], resp_w[2], po_w[2], pv_w[2], bz_w[2], dn_w[2], int'(err2), fp_w[2], fv_w[2]);
   end

   // Starts a sweep and returns the cycle index (start edge = 0) in which done is seen.
   task automatic run(input int id, input logic [1:0] md, input bit junk, output int dc);
      int cyc;
      dc = -1;
      @(posedge clk); #1;
      st_r[id] = 1'b1;
      md_r[id] = md;
      @(posedge clk); #1;
      st_r[id] = 1'b0;
      cyc = 1;
      while (cyc < 2000 && dc < 0) begin
         if (dn_w[id]) begin
            dc = cyc;
         end else begin
            if (junk) begin
               st_r[id] = ((cyc % 5) == 2);
               md_r[id] = 2'($urandom_range(0, 3));
            end
            @(posedge clk); #1;
            cyc++;
         end
      end
      st_r[id] = 1'b0;
      cmp($sformatf("u%0d done seen", id), dn_w[id], 1);
   endtask

   initial begin
      int dc;
      for (int i = 0; i < 3; i++) begin
         st_r[i]   = 1'b0;
         md_r[i]   = 2'd0;
         fn_r[i]   = 2'd0;
         kind_r[i] = 0;
      end
      #1;
      cmp("reset pat_out", po_w[0], 0);
      cmp("reset pat_valid", pv_w[0], 0);
      cmp("reset busy", bz_w[0], 0);
      cmp("reset done", dn_w[0], 0);
      cmp("reset err_cnt", err0, 0);
      cmp("reset first_err_vld", fv_w[0], 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // clean NAND sweep
      run(0, 2'd0, 1'b0, dc);
      cmp("t1 done cycle", dc, 18);
      cmp("t1 err_cnt", err0, 0);

      // stuck-at-1 DUT: only pattern F disagrees
      kind_r[0] = 1;
      run(0, 2'd0, 1'b0, dc);
      cmp("t2 err_cnt", err0, 1);
`ifdef NAND_SWEEP_FIRST_ERR_EN
      cmp("t2 first_err_pat", fp_w[0], 15);
      cmp("t2 first_err_vld", fv_w[0], 1);
`endif

      // AND golden against a NAND DUT: every pattern fails
      kind_r[0] = 0;
      run(0, 2'd1, 1'b0, dc);
      cmp("t3 err_cnt", err0, 16);
`ifdef NAND_SWEEP_FIRST_ERR_EN
      cmp("t3 first_err_pat", fp_w[0], 0);
      cmp("t3 first_err_vld", fv_w[0], 1);
`endif

      // HOLD=3, LAT=4 XOR with start/mode noise during the sweep
      fn_r[1] = 2'd3;
      run(1, 2'd3, 1'b1, dc);
      cmp("t4 done cycle", dc, 53);
      cmp("t4 err_cnt", err1, 0);
      st_r[1] = 1'b1;
      @(posedge clk); #1;
      st_r[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cmp("t4 start in done ignored", bz_w[1], 0);
         @(posedge clk); #1;
      end

      // reset mid-sweep with an always-wrong DUT
      kind_r[0] = 2;
      @(posedge clk); #1;
      st_r[0] = 1'b1;
      md_r[0] = 2'd0;
      @(posedge clk); #1;
      st_r[0] = 1'b0;
      for (int i = 0; i < 100 && po_w[0] != 4'd7; i++) begin
         @(posedge clk); #1;
      end
      cmp("t5 reached pattern 7", po_w[0], 7);
      cmp("t5 err before reset", err0, 6);
      rst_n = 1'b0;
      #1;
      cmp("t5 reset pat_out", po_w[0], 0);
      cmp("t5 reset pat_valid", pv_w[0], 0);
      cmp("t5 reset busy", bz_w[0], 0);
      cmp("t5 reset err_cnt", err0, 0);
      cmp("t5 reset first_err_vld", fv_w[0], 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cmp("t5 no done after reset", dn_w[0], 0);
         @(posedge clk); #1;
      end
      kind_r[0] = 0;
      run(0, 2'd0, 1'b0, dc);
      cmp("t5 restart done cycle", dc, 18);
      cmp("t5 restart err_cnt", err0, 0);

      // saturation at 2^3-1
      kind_r[2] = 2;
      run(2, 2'd0, 1'b0, dc);
      cmp("t6 done cycle", dc, 18);
      cmp("t6 err_cnt saturated", err2, 7);
`ifdef NAND_SWEEP_FIRST_ERR_EN
      cmp("t6 first_err_pat", fp_w[2], 0);
`endif

      @(posedge clk); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
